// File: rtl/wide_alu_serial.sv
// rtl/wide_alu_serial.sv - multi-cycle arbitrary-width ALU, one LIMB-bit slice per clock
// Operands are latched zero-padded to NLIMBS*LIMB bits and shifted right one limb per RUN edge.
module wide_alu_serial #(
  parameter int WIDTH = 100,
  parameter int LIMB  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);
  localparam int NLIMBS = (WIDTH + LIMB - 1) / LIMB;
  localparam int PW     = NLIMBS * LIMB;
  localparam int CW     = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
  localparam int TOPB   = WIDTH - (NLIMBS - 1) * LIMB;
  localparam logic [PW-1:0] MASK = PW'({WIDTH{1'b1}});

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_NOT = 3'd5, OP_RAND = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   xr_q, yr_q, mr_q, racc_q, racc_d;
  logic [2:0]      opr_q;
  logic            c_q, acc_q, c_d, acc_d, last, is_red, is_arith;
  logic [LIMB-1:0] xl, yl, ml, yv, rl;
  logic [LIMB:0]   s;
  logic [WIDTH-1:0] fin;

  always_comb begin
    xl  = xr_q[LIMB-1:0];
    yl  = yr_q[LIMB-1:0];
    ml  = mr_q[LIMB-1:0];
    // Padding bits are masked off the subtrahend too, so the carry lands exactly at bit WIDTH
    yv  = ((opr_q == OP_SUB) ? ~yl : yl) & ml;
    s   = {1'b0, xl} + {1'b0, yv} + {{LIMB{1'b0}}, c_q};
    last = (cnt_q == CW'(NLIMBS - 1));
    c_d  = last ? s[TOPB] : s[LIMB];
    acc_d = acc_q;
    rl    = '0;
    case (opr_q)
      OP_ADD, OP_SUB: rl = s[LIMB-1:0];
      OP_AND:  rl = xl & yl;
      OP_OR:   rl = xl | yl;
      OP_XOR:  rl = xl ^ yl;
      OP_NOT:  rl = ~xl & ml;
      OP_RAND: acc_d = acc_q & (&(xl | ~ml));
      default: acc_d = acc_q | (|xl);
    endcase
    racc_d = racc_q >> LIMB;
    racc_d[PW-1 -: LIMB] = rl;
    is_red   = opr_q[2] & opr_q[1];
    is_arith = (opr_q == OP_ADD) || (opr_q == OP_SUB);
    fin = is_red ? WIDTH'(acc_d) : racc_d[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      xr_q      <= '0;
      yr_q      <= '0;
      mr_q      <= '0;
      racc_q    <= '0;
      opr_q     <= '0;
      c_q       <= 1'b0;
      acc_q     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          xr_q   <= PW'(x);
          yr_q   <= PW'(y);
          mr_q   <= MASK;
          opr_q  <= op;
          racc_q <= '0;
          c_q    <= (op == OP_SUB);
          acc_q  <= (op == OP_RAND);
          cnt_q  <= '0;
        end
        RUN: begin
          xr_q   <= xr_q >> LIMB;
          yr_q   <= yr_q >> LIMB;
          mr_q   <= mr_q >> LIMB;
          racc_q <= racc_d;
          c_q    <= c_d;
          acc_q  <= acc_d;
          cnt_q  <= last ? '0 : cnt_q + CW'(1);
          // Visible outputs only change once the whole operation is complete
          if (last) begin
            result    <= fin;
            carry_out <= is_arith ? c_d : 1'b0;
            zero      <= (fin == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wide_alu_serial.sv
// tb/tb_wide_alu_serial.sv - directed table-driven bench for wide_alu_serial at three parameter sets
module tb_wide_alu_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  op = 3'd0;
  logic [99:0] x = '0, y = '0;
  logic        out_ready = 1'b1;
  logic [2:0]  iv = '0, inr, ov, co, zr;
  logic [99:0] res0, res2;
  logic [7:0]  res1;

  wide_alu_serial u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(inr[0]), .op(op),
    .x(x), .y(y), .out_valid(ov[0]), .out_ready(out_ready), .result(res0),
    .carry_out(co[0]), .zero(zr[0]));
  wide_alu_serial #(.WIDTH(8), .LIMB(8)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]),
    .in_ready(inr[1]), .op(op), .x(x[7:0]), .y(y[7:0]), .out_valid(ov[1]),
    .out_ready(out_ready), .result(res1), .carry_out(co[1]), .zero(zr[1]));
  wide_alu_serial #(.WIDTH(100), .LIMB(7)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]),
    .in_ready(inr[2]), .op(op), .x(x), .y(y), .out_valid(ov[2]), .out_ready(out_ready),
    .result(res2), .carry_out(co[2]), .zero(zr[2]));

  typedef struct {
    int          d;
    logic [2:0]  op;
    logic [99:0] a, b, er;
    logic        ec, ez;
  } vec_t;
  vec_t v[$];
  int exp_lat[3] = '{7, 1, 15};

  localparam logic [99:0] ONES = 100'hf_ffff_ffff_ffff_ffff_ffff_ffff;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [99:0] a, input logic [99:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic [99:0] get_res(input int d);
    case (d)
      0:       return res0;
      1:       return {92'b0, res1};
      default: return res2;
    endcase
  endfunction

  function automatic void add(input int d, input logic [2:0] o, input logic [99:0] a,
                              input logic [99:0] b, input logic [99:0] r,
                              input logic c, input logic z);
    vec_t t;
    t.d = d; t.op = o; t.a = a; t.b = b; t.er = r; t.ec = c; t.ez = z;
    v.push_back(t);
  endfunction

  // Called at a negedge; returns at the negedge where out_valid is first seen high.
  task automatic do_op(input int d, input logic [2:0] o, input logic [99:0] a,
                       input logic [99:0] b, output int lat);
    int w;
    w = 0;
    while (!inr[d] && w < 50) begin @(negedge clk); w++; end
    chk("in_ready before op", {99'b0, inr[d]}, 100'd1);
    op = o; x = a; y = b; iv[d] = 1'b1;
    @(negedge clk);
    iv[d] = 1'b0;
    op = ~o; x = ~a; y = ~b;
    lat = 0;
    while (!ov[d] && lat < 100) begin @(negedge clk); lat++; end
  endtask

  initial begin
    int lat, seen;
    // Boundary and regression vectors: {dut, op, x, y, result, carry_out, zero}
    add(0, 3'd0, 100'd1, 100'd2, 100'd3, 1'b0, 1'b0);
    add(0, 3'd0, 100'hffff_ffff_ffff_ffff, 100'd2, 100'h1_0000_0000_0000_0001, 1'b0, 1'b0);
    add(0, 3'd0, ONES, 100'd1, 100'd0, 1'b1, 1'b1);
    add(0, 3'd1, 100'd1, 100'd2, ONES, 1'b0, 1'b0);
    add(0, 3'd1, 100'h1234, 100'h1234, 100'd0, 1'b1, 1'b1);
    add(0, 3'd1, 100'd5, 100'd3, 100'd2, 1'b1, 1'b0);
    add(0, 3'd2, 100'hff00, 100'h0ff0, 100'h0f00, 1'b0, 1'b0);
    add(0, 3'd3, 100'hff00, 100'h0ff0, 100'hfff0, 1'b0, 1'b0);
    add(0, 3'd4, 100'hff00, 100'h0ff0, 100'hf0f0, 1'b0, 1'b0);
    add(0, 3'd5, 100'd0, 100'd7, ONES, 1'b0, 1'b0);
    add(0, 3'd6, ONES, 100'd0, 100'd1, 1'b0, 1'b0);
    add(0, 3'd6, 100'h7_ffff_ffff_ffff_ffff_ffff_ffff, 100'd0, 100'd0, 1'b0, 1'b1);
    add(0, 3'd7, 100'd0, ONES, 100'd0, 1'b0, 1'b1);
    add(0, 3'd7, 100'h8_0000_0000_0000_0000_0000_0000, 100'd0, 100'd1, 1'b0, 1'b0);
    add(1, 3'd0, 100'd1, 100'd2, 100'd3, 1'b0, 1'b0);
    add(1, 3'd0, 100'hff, 100'd2, 100'h01, 1'b1, 1'b0);
    add(1, 3'd0, 100'hff, 100'd1, 100'd0, 1'b1, 1'b1);
    add(1, 3'd1, 100'd1, 100'd2, 100'hff, 1'b0, 1'b0);
    add(2, 3'd0, 100'd1, 100'd2, 100'd3, 1'b0, 1'b0);
    add(2, 3'd0, 100'hffff_ffff_ffff_ffff, 100'd2, 100'h1_0000_0000_0000_0001, 1'b0, 1'b0);
    add(2, 3'd0, ONES, 100'd1, 100'd0, 1'b1, 1'b1);
    add(2, 3'd1, 100'd1, 100'd2, ONES, 1'b0, 1'b0);
    add(2, 3'd6, ONES, 100'd0, 100'd1, 1'b0, 1'b0);
    add(2, 3'd5, 100'd0, 100'd0, ONES, 1'b0, 1'b0);

    #12;
    chk("reset in_ready", {99'b0, inr[0]}, 100'd1);
    chk("reset out_valid", {99'b0, ov[0]}, 100'd0);
    chk("reset result", res0, 100'd0);
    chk("reset carry/zero", {98'b0, co[0], zr[0]}, 100'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    out_ready = 1'b1;
    foreach (v[i]) begin
      do_op(v[i].d, v[i].op, v[i].a, v[i].b, lat);
      chk($sformatf("v%0d result", i), get_res(v[i].d), v[i].er);
      chk($sformatf("v%0d carry_out", i), {99'b0, co[v[i].d]}, {99'b0, v[i].ec});
      chk($sformatf("v%0d zero", i), {99'b0, zr[v[i].d]}, {99'b0, v[i].ez});
      chk($sformatf("v%0d latency", i), 100'(lat), 100'(exp_lat[v[i].d]));
      @(negedge clk);
      chk($sformatf("v%0d post-handshake valid/ready", i), {98'b0, ov[v[i].d], inr[v[i].d]},
          100'b01);
    end

    // Backpressure: result frozen, no new acceptance while DONE
    out_ready = 1'b0;
    do_op(0, 3'd0, 100'd5, 100'd7, lat);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d result", i), res0, 100'd12);
      chk($sformatf("bp%0d valid/ready", i), {98'b0, ov[0], inr[0]}, 100'b10);
      iv[0] = (i == 2);
      op = 3'd1; x = 100'd9; y = 100'd1;
      @(negedge clk);
    end
    iv[0] = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release valid/ready", {98'b0, ov[0], inr[0]}, 100'b01);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk("bp single handshake", 100'(seen), 100'd0);
    chk("bp result held", res0, 100'd12);

    // Reset in the middle of RUN
    do_op(0, 3'd0, 100'd1, 100'd2, lat);
    @(negedge clk);
    op = 3'd0; x = ONES; y = ONES; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun reset valid/ready", {98'b0, ov[0], inr[0]}, 100'b01);
    chk("midrun reset zero", {99'b0, zr[0]}, 100'd1);
    chk("midrun reset result", res0, 100'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(0, 3'd4, 100'h1_0000_0000_0000_0000_0000_00ff, 100'h0ff, lat);
    chk("after reset result", res0, 100'h1_0000_0000_0000_0000_0000_0000);
    chk("after reset latency", 100'(lat), 100'd7);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
